// File: rtl/instr_pkg.sv
// Shared ISA definitions for the single-cycle MIPS core: opcodes, instruction kinds,
// loader FSM states and the field bundle handed to the word encoder.
package instr_pkg;

    // Opcode values are shared with the main-control decoder; keep them in sync.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_LW  = 3'd1,
        KIND_SW  = 3'd2,
        KIND_BEQ = 3'd3,
        KIND_J   = 3'd4,
        KIND_LUI = 3'd5,
        KIND_ORI = 3'd6,
        KIND_BNE = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

endpackage

// File: rtl/instr_word_encode.sv
// Combinational field-to-word encoder; illegal kinds produce a NOP and raise illegal.
// Optional build macro ISA_BNE_EN: when defined, kind 7 encodes BNE instead of being illegal.
module instr_word_encode
    import instr_pkg::*;
(
    input  logic [2:0]    kind,
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (kind_e'(kind))
            KIND_R:   word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
            KIND_LW:  word = {OP_LW,  fields.rs, fields.rt, fields.imm};
            KIND_SW:  word = {OP_SW,  fields.rs, fields.rt, fields.imm};
            KIND_BEQ: word = {OP_BEQ, fields.rs, fields.rt, fields.imm};
            KIND_J:   word = {OP_J,   fields.target};
            KIND_LUI: word = {OP_LUI, 5'd0, fields.rt, fields.imm};
            KIND_ORI: word = {OP_ORI, fields.rs, fields.rt, fields.imm};
`ifdef ISA_BNE_EN
            KIND_BNE: word = {OP_BNE, fields.rs, fields.rt, fields.imm};
`else
            KIND_BNE: illegal = 1'b1;
`endif
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams field-level instructions into instruction memory, one registered write per accept.
// Optional build macro ISA_BNE_EN selects whether kind 7 encodes BNE (see instr_word_encode).
module instr_stream_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              kind_err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              at_end;
    instr_fields_t     fields;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                      funct: in_funct, imm: in_imm, target: in_target};

    instr_word_encode u_encode (
        .kind    (in_kind),
        .fields  (fields),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD);
    assign done     = (state == ST_DONE);
    // start wins over a simultaneous accept: the beat is dropped even though in_ready is high.
    assign accept   = in_valid & in_ready & ~start;
    assign at_end   = (ptr == LAST_ADDR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_LOAD;
        end else if (accept && (in_last || at_end)) begin
            state_nxt = ST_DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            kind_err   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept;
            if (start) begin
                ptr      <= BASE;
                count    <= '0;
                overflow <= 1'b0;
                kind_err <= 1'b0;
            end else if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= enc_word;
                count      <= count + (ADDR_W + 1)'(1);
                // The pointer parks on the top word rather than wrapping to 0.
                if (!at_end) begin
                    ptr <= ptr + ADDR_W'(1);
                end
                if (at_end && !in_last) begin
                    overflow <= 1'b1;
                end
                if (enc_illegal) begin
                    kind_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: two instances (ADDR_W=8/BASE=4 and ADDR_W=2/BASE=0).
// Expected writes are queued when stimulus is driven and popped by per-instance write monitors.
module tb_instr_stream_encoder;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_a, start_b, valid_a, valid_b;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;

    logic        a_ready, a_we, a_busy, a_done, a_ovf, a_kerr;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    logic        b_ready, b_we, b_busy, b_done, b_ovf, b_kerr;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    wr_t q_a[$];
    wr_t q_b[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    instr_stream_encoder #(.ADDR_W(8), .BASE_ADDR(4)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .in_valid(valid_a), .in_ready(a_ready),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
        .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy),
        .done(a_done), .overflow(a_ovf), .kind_err(a_kerr), .count(a_count)
    );

    instr_stream_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .in_valid(valid_b), .in_ready(b_ready),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
        .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy),
        .done(b_done), .overflow(b_ovf), .kind_err(b_kerr), .count(b_count)
    );

    // Write monitors: every observed write must match the head of its instance's queue.
    always @(negedge clk) begin
        if (rstn === 1'b1 && a_we === 1'b1) begin
            n_checks++;
            if (q_a.size() == 0) begin
                $display("FAIL a_write: unexpected write addr=%0d data=%h, none required", a_addr, a_wdata);
            end else begin
                wr_t e;
                e = q_a.pop_front();
                if (a_addr !== e.addr || a_wdata !== e.data)
                    $display("FAIL a_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             a_addr, a_wdata, e.addr, e.data);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1 && b_we === 1'b1) begin
            n_checks++;
            if (q_b.size() == 0) begin
                $display("FAIL b_write: unexpected write addr=%0d data=%h, none required", b_addr, b_wdata);
            end else begin
                wr_t e;
                e = q_b.pop_front();
                if ({6'd0, b_addr} !== e.addr || b_wdata !== e.data)
                    $display("FAIL b_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             b_addr, b_wdata, e.addr, e.data);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit to_b);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Drives one beat for one cycle; queues the expected write when one is required.
    task automatic send(input bit to_b, input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] tg, input logic lst,
                        input logic [7:0] ea, input logic [31:0] ew);
        wr_t e;
        kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
        imm = im; target = tg; last = lst;
        e.addr = ea;
        e.data = ew;
        if (to_b) begin
            valid_b = 1'b1;
            q_b.push_back(e);
        end else begin
            valid_a = 1'b1;
            q_a.push_back(e);
        end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
        imm = '0; target = '0; last = 1'b0;
        #12;
        n_checks++;
        if ({a_ready, a_we, a_busy, a_done, a_ovf, a_kerr, a_count, a_addr, a_wdata} !== '0)
            $display("FAIL reset_a: got rdy=%b we=%b busy=%b done=%b ovf=%b kerr=%b cnt=%0d addr=%0d data=%h, required all 0",
                     a_ready, a_we, a_busy, a_done, a_ovf, a_kerr, a_count, a_addr, a_wdata);
        else n_pass++;
        n_checks++;
        if ({b_ready, b_we, b_busy, b_done, b_ovf, b_kerr, b_count, b_addr, b_wdata} !== '0)
            $display("FAIL reset_b: got rdy=%b we=%b busy=%b done=%b ovf=%b kerr=%b cnt=%0d addr=%0d data=%h, required all 0",
                     b_ready, b_we, b_busy, b_done, b_ovf, b_kerr, b_count, b_addr, b_wdata);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_r_format;
        pulse_start(1'b1);
        n_checks++;
        if ({b_busy, b_done, b_ovf, b_kerr, b_ready, b_count} !== {5'b10001, 3'd0})
            $display("FAIL r_load_status: got %b, required %b",
                     {b_busy, b_done, b_ovf, b_kerr, b_ready, b_count}, {5'b10001, 3'd0});
        else n_pass++;
        send(1'b1, 3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 8'd0, 32'h0109_5020);
        n_checks++;
        if ({b_busy, b_done, b_ovf, b_kerr, b_ready, b_count} !== {5'b01000, 3'd1})
            $display("FAIL r_done_status: got %b, required %b",
                     {b_busy, b_done, b_ovf, b_kerr, b_ready, b_count}, {5'b01000, 3'd1});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (b_we !== 1'b0) $display("FAIL r_we_drop: got we=%b, required 0", b_we);
        else n_pass++;
    endtask

    task automatic test_mixed_burst;
        pulse_start(1'b0);
        send(1'b0, 3'd1, 5'd29, 5'd8,  5'd0, 5'd0, 6'd0, 16'h0004, 26'h0,  1'b0, 8'd4, 32'h8FA8_0004);
        send(1'b0, 3'd4, 5'd0,  5'd0,  5'd0, 5'd0, 6'd0, 16'h0,    26'h10, 1'b0, 8'd5, 32'h0800_0010);
        send(1'b0, 3'd5, 5'd7,  5'd1,  5'd0, 5'd0, 6'd0, 16'h1234, 26'h0,  1'b0, 8'd6, 32'h3C01_1234);
        send(1'b0, 3'd6, 5'd2,  5'd3,  5'd0, 5'd0, 6'd0, 16'h00FF, 26'h0,  1'b0, 8'd7, 32'h3443_00FF);
        send(1'b0, 3'd2, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0008, 26'h0,  1'b0, 8'd8, 32'hAFBF_0008);
        send(1'b0, 3'd3, 5'd4,  5'd5,  5'd0, 5'd0, 6'd0, 16'hFFFE, 26'h0,  1'b1, 8'd9, 32'h1085_FFFE);
        n_checks++;
        if ({a_busy, a_done, a_ovf, a_kerr, a_ready, a_count} !== {5'b01000, 9'd6})
            $display("FAIL burst_status: got %b, required %b",
                     {a_busy, a_done, a_ovf, a_kerr, a_ready, a_count}, {5'b01000, 9'd6});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_kind7;
        logic [31:0] exp_word;
        logic        exp_kerr;
`ifdef ISA_BNE_EN
        exp_word = 32'h1422_FFFF;
        exp_kerr = 1'b0;
`else
        exp_word = 32'h0000_0000;
        exp_kerr = 1'b1;
`endif
        pulse_start(1'b0);
        send(1'b0, 3'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b1, 8'd4, exp_word);
        n_checks++;
        if (a_kerr !== exp_kerr || a_count !== 9'd1 || a_done !== 1'b1)
            $display("FAIL kind7_flags: got kerr=%b cnt=%0d done=%b, required kerr=%b cnt=1 done=1",
                     a_kerr, a_count, a_done, exp_kerr);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++)
            send(1'b1, 3'd6, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, 1'b0,
                 8'(i), 32'h3443_0000 | 32'(i));
        n_checks++;
        if ({b_busy, b_done, b_ovf, b_kerr, b_ready, b_count} !== {5'b01100, 3'd4})
            $display("FAIL ovf_status: got %b, required %b",
                     {b_busy, b_done, b_ovf, b_kerr, b_ready, b_count}, {5'b01100, 3'd4});
        else n_pass++;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        n_checks++;
        if (b_we !== 1'b0 || b_count !== 3'd4 || b_ovf !== 1'b1)
            $display("FAIL ovf_fifth: got we=%b cnt=%0d ovf=%b, required we=0 cnt=4 ovf=1",
                     b_we, b_count, b_ovf);
        else n_pass++;
    endtask

    task automatic test_restart;
        pulse_start(1'b0);
        send(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h25, 16'h0, 26'h0, 1'b0, 8'd4, 32'h0022_1925);
        send(1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0,  16'h0, 26'h3FFFFFF, 1'b0, 8'd5, 32'h0BFF_FFFF);
        send(1'b0, 3'd5, 5'd9, 5'd4, 5'd0, 5'd0, 6'd0,  16'hBEEF, 26'h0, 1'b0, 8'd6, 32'h3C04_BEEF);
        start_a = 1'b1;
        valid_a = 1'b1;
        kind = 3'd1;
        #1;
        n_checks++;
        if (a_ready !== 1'b1) $display("FAIL restart_ready: got %b, required 1", a_ready);
        else n_pass++;
        @(negedge clk);
        start_a = 1'b0;
        valid_a = 1'b0;
        n_checks++;
        if ({a_we, a_busy, a_done, a_ovf, a_kerr, a_count} !== {5'b01000, 9'd0})
            $display("FAIL restart_state: got %b, required %b",
                     {a_we, a_busy, a_done, a_ovf, a_kerr, a_count}, {5'b01000, 9'd0});
        else n_pass++;
        send(1'b0, 3'd6, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'h0, 1'b1, 8'd4, 32'h3401_0001);
        n_checks++;
        if (a_count !== 9'd1 || a_done !== 1'b1)
            $display("FAIL restart_after: got cnt=%0d done=%b, required cnt=1 done=1", a_count, a_done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        pulse_start(1'b0);
        send(1'b0, 3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 1'b0, 8'd4, 32'h8C43_0010);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({a_we, a_busy, a_ready, a_count, a_addr, a_wdata} !== '0)
            $display("FAIL async_rst: got we=%b busy=%b rdy=%b cnt=%0d addr=%0d data=%h, required all 0",
                     a_we, a_busy, a_ready, a_count, a_addr, a_wdata);
        else n_pass++;
        #1;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_we, a_busy, a_done, a_ovf, a_kerr, a_ready, a_count} !== '0)
            $display("FAIL async_after: got %b, required all 0",
                     {a_we, a_busy, a_done, a_ovf, a_kerr, a_ready, a_count});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_r_format();
        test_mixed_burst();
        test_kind7();
        test_overflow();
        test_restart();
        test_async_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL drain: got %0d/%0d pending writes, required 0/0", q_a.size(), q_b.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
